// File: rtl/tl_pkg.sv
// TileLink-UH constants and state type shared by the IL1 refill path.
package tl_pkg;

    localparam logic [2:0] A_GET       = 3'd4;
    localparam logic [2:0] A_PUT_FULL  = 3'd0;

    localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

    localparam int BEAT_W = 128;
    localparam int MASK_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        GRANT,
        DONE
    } il1_state_e;

    function automatic int line_off_w(input int beats);
        return $clog2(16 * beats);
    endfunction

endpackage

// File: rtl/il1_refill_master_if.sv
// Refill request/response plus TileLink A/D channel bundle.
interface il1_refill_master_if
    import tl_pkg::*;
#(
    parameter int LINE_BEATS = 2
);

    logic                         req_valid;
    logic                         req_ready;
    logic [31:0]                  req_addr;
    logic                         flush;

    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [BEAT_W*LINE_BEATS-1:0] rsp_data;
    logic                         rsp_denied;
    logic                         rsp_corrupt;

    logic                         a_valid;
    logic                         a_ready;
    logic [2:0]                   a_opcode;
    logic [2:0]                   a_param;
    logic [7:0]                   a_size;
    logic [2:0]                   a_source;
    logic [31:0]                  a_address;
    logic [MASK_W-1:0]            a_mask;
    logic [BEAT_W-1:0]            a_data;
    logic                         a_corrupt;

    logic                         d_valid;
    logic                         d_ready;
    logic [2:0]                   d_opcode;
    logic [1:0]                   d_param;
    logic [7:0]                   d_size;
    logic [2:0]                   d_source;
    logic [2:0]                   d_sink;
    logic                         d_denied;
    logic [BEAT_W-1:0]            d_data;
    logic                         d_corrupt;

    modport master (
        input  req_valid, req_addr, flush, rsp_ready,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_size,
        input  d_source, d_sink, d_denied, d_data, d_corrupt,
        output req_ready, rsp_valid, rsp_data,
        output rsp_denied, rsp_corrupt,
        output a_valid, a_opcode, a_param, a_size,
        output a_source, a_address, a_mask, a_data, a_corrupt,
        output d_ready
    );

    modport slave (
        output req_valid, req_addr, flush, rsp_ready,
        output a_ready,
        output d_valid, d_opcode, d_param, d_size,
        output d_source, d_sink, d_denied, d_data, d_corrupt,
        input  req_ready, rsp_valid, rsp_data,
        input  rsp_denied, rsp_corrupt,
        input  a_valid, a_opcode, a_param, a_size,
        input  a_source, a_address, a_mask, a_data, a_corrupt,
        input  d_ready
    );

endinterface

// File: rtl/tl_beat_assembler.sv
// Beat counter and per-slot line register for multi-beat D responses.
module tl_beat_assembler
    import tl_pkg::*;
#(
    parameter int LINE_BEATS = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clr,
    input  logic                         wr,
    input  logic [BEAT_W-1:0]            wdata,
    output logic [BEAT_W*LINE_BEATS-1:0] line,
    output logic                         last
);

    localparam int CW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(LINE_BEATS - 1);

    logic [CW-1:0]     cnt;
    logic [BEAT_W-1:0] slot_q [LINE_BEATS];

    assign last = (cnt == LAST_IDX);

    // Counter wraps after the last beat so a line never writes past its end.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (wr) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LINE_BEATS; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LINE_BEATS; i++) begin
                if (wr && cnt == CW'(i)) begin
                    slot_q[i] <= wdata;
                end
            end
        end
    end

    for (genvar g = 0; g < LINE_BEATS; g++) begin : g_line
        assign line[g*BEAT_W +: BEAT_W] = slot_q[g];
    end

endmodule

// File: rtl/il1_refill_master.sv
// IL1 refill Get initiator: one line miss -> one Get -> assembled line.
module il1_refill_master
    import tl_pkg::*;
#(
    parameter int         LINE_BEATS = 2,
    parameter logic [2:0] SOURCE_ID  = 3'd0
) (
    input  logic                clock,
    input  logic                reset,
    il1_refill_master_if.master bus
);

    localparam int          OFF_W    = line_off_w(LINE_BEATS);
    localparam logic [31:0] OFF_MASK = 32'((64'd1 << OFF_W) - 64'd1);

    il1_state_e  state, state_d;
    logic [31:0] addr_q;
    logic        denied_q;
    logic        corrupt_q;
    logic        killed_q;
    logic        accept;
    logic        beat;
    logic        last;
    logic        bad_beat;
    logic        unused_d;

    assign accept   = (state == IDLE) && bus.req_valid;
    assign beat     = (state == GRANT) && bus.d_valid;
    assign bad_beat = (bus.d_opcode != D_ACCESS_ACK_DATA)
                   || (bus.d_source != SOURCE_ID);
    assign unused_d = ^{bus.d_param, bus.d_size, bus.d_sink};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // D cannot be abandoned, so a flush in GRANT only suppresses the response.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:  if (bus.req_valid) state_d = ACQ;
            ACQ: begin
                if (bus.a_ready)    state_d = GRANT;
                else if (bus.flush) state_d = IDLE;
            end
            GRANT: begin
                if (beat && last) begin
                    state_d = (killed_q || bus.flush) ? IDLE : DONE;
                end
            end
            DONE:  if (bus.rsp_ready || bus.flush) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q    <= '0;
            denied_q  <= 1'b0;
            corrupt_q <= 1'b0;
            killed_q  <= 1'b0;
        end else if (accept) begin
            addr_q    <= bus.req_addr & ~OFF_MASK;
            denied_q  <= 1'b0;
            corrupt_q <= 1'b0;
            killed_q  <= 1'b0;
        end else if (state == GRANT) begin
            if (beat) begin
                denied_q  <= denied_q | bus.d_denied;
                corrupt_q <= corrupt_q | bus.d_corrupt | bad_beat;
            end
            if (bus.flush) begin
                killed_q <= 1'b1;
            end
        end
    end

    tl_beat_assembler #(
        .LINE_BEATS (LINE_BEATS)
    ) u_asm (
        .clock (clock),
        .reset (reset),
        .clr   (accept),
        .wr    (beat),
        .wdata (bus.d_data),
        .line  (bus.rsp_data),
        .last  (last)
    );

    assign bus.req_ready   = (state == IDLE);
    assign bus.a_valid     = (state == ACQ);
    assign bus.a_opcode    = bus.a_valid ? A_GET : 3'd0;
    assign bus.a_param     = 3'd0;
    assign bus.a_size      = bus.a_valid ? 8'(OFF_W) : 8'd0;
    assign bus.a_source    = bus.a_valid ? SOURCE_ID : 3'd0;
    assign bus.a_address   = bus.a_valid ? addr_q : 32'd0;
    assign bus.a_mask      = bus.a_valid ? {MASK_W{1'b1}} : '0;
    assign bus.a_data      = '0;
    assign bus.a_corrupt   = 1'b0;
    assign bus.d_ready     = (state == GRANT);
    assign bus.rsp_valid   = (state == DONE);
    assign bus.rsp_denied  = denied_q;
    assign bus.rsp_corrupt = corrupt_q;

endmodule
